// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder feeding a 2-entry output FIFO with a byte-address counter.
// Define ENC_RANGE_CHECK_EN to reject immediates that do not fit their format.
module instr_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   input  logic        addr_load,
   input  logic [31:0] addr_val,
   output logic        err,
   output logic [1:0]  level
);

   localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                          FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5;

   logic [31:0]      enc;
   logic             legal;
   logic             range_ok;
   logic [1:0][31:0] mem;
   logic             wr_ptr, rd_ptr;
   logic [1:0]       cnt;
   logic [31:0]      addr;
   logic             accept, push, pop, ok;

   always_comb begin
      enc   = '0;
      legal = 1'b1;
      case (fmt)
         FMT_R: enc = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            // SLLI/SRLI/SRAI carry funct7 in the upper bits and a 5-bit shamt
            if (opcode == 7'b0010011 && (funct3 == 3'b001 || funct3 == 3'b101))
               enc = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            else
               enc = {imm[11:0], rs1, funct3, rd, opcode};
         end
         FMT_S: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         FMT_U: enc = {imm[31:12], rd, opcode};
         FMT_J: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: legal = 1'b0;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   always_comb begin
      range_ok = 1'b1;
      case (fmt)
         FMT_I, FMT_S: range_ok = (imm[31:11] == {21{imm[11]}});
         FMT_B:        range_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
         FMT_U:        range_ok = (imm[11:0] == 12'h000);
         FMT_J:        range_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
         default:      range_ok = 1'b1;
      endcase
   end
`else
   assign range_ok = 1'b1;
`endif

   assign ok        = legal && range_ok;
   assign out_valid = (cnt != 2'd0);
   assign level     = cnt;
   // Full FIFO can still accept when the head leaves in the same cycle
   assign in_ready  = (cnt != 2'd2) || out_ready;
   assign accept    = in_valid && in_ready;
   assign push      = accept && ok;
   assign pop       = out_valid && out_ready;
   assign out_instr = out_valid ? mem[rd_ptr] : '0;
   assign out_addr  = addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
         err    <= 1'b0;
         addr   <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= enc;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         cnt <= cnt + 2'(push) - 2'(pop);
         err <= accept && !ok;
         if (addr_load)
            addr <= {addr_val[31:2], 2'b00};
         else if (pop)
            addr <= addr + 32'd4;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: stimulus pushes expected words, a monitor pops on each handshake.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_addr;
   logic        addr_load;
   logic [31:0] addr_val;
   logic        err;
   logic [1:0]  level;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
   } exp_t;
   exp_t q[$];

   int n_vec = 0;
   int n_err = 0;

   instr_encoder dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .addr_load(addr_load), .addr_val(addr_val),
      .err(err), .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor samples just before the rising edge, after all driver updates
   always @(negedge clk) begin
      #4;
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got %h at %h, expected none", out_instr, out_addr);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_instr", out_instr, e.instr);
            chk("out_addr", out_addr, e.addr);
         end
      end
   end

   // Called just after a falling edge; returns just after the falling edge following acceptance
   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im,
                       input logic [31:0] ei, input logic [31:0] ea, input logic bad);
      int k;
      fmt = f; opcode = op; funct3 = f3; funct7 = f7;
      rd = d; rs1 = s1; rs2 = s2; imm = im;
      in_valid = 1'b1;
      #1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk); #1;
         k++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: got in_ready=0, expected 1");
         in_valid = 1'b0;
         return;
      end
      if (!bad) q.push_back('{instr: ei, addr: ea});
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("err", {31'b0, err}, {31'b0, bad});
   endtask

   task automatic load(input logic [31:0] a);
      addr_load = 1'b1;
      addr_val  = a;
      @(negedge clk);
      addr_load = 1'b0;
      #1;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      #1;
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      fmt = '0; opcode = '0; funct3 = '0; funct7 = '0;
      rd = '0; rs1 = '0; rs2 = '0; imm = '0;
      addr_load = 1'b0; addr_val = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_level", {30'b0, level}, 0);
      chk("rst_err", {31'b0, err}, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_addr", out_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 1);

      // ADDI x1,x0,5
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 32'h0, 1'b0);
      drain();

      // Back-to-back mix of formats
      load(32'h0);
      send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 32'h00, 1'b0);
      send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd12, 32'h0020A623, 32'h04, 1'b0);
      send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 32'h08, 1'b0);
      send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h800, 32'h001000EF, 32'h0C, 1'b0);
      send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 32'h10, 1'b0);
      send(3'd1, 7'h13, 3'd5, 7'h20, 5'd2, 5'd1, 5'd0, 32'd3, 32'h4030D113, 32'h14, 1'b0);
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0, 32'hFFFFFFFF, 32'hFFF08093, 32'h18, 1'b0);
      drain();

      // Backpressure: two fill the FIFO, the third waits for out_ready
      load(32'h0);
      out_ready = 1'b0;
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 32'h0, 1'b0);
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd5, 32'h00500113, 32'h4, 1'b0);
      chk("full_level", {30'b0, level}, 2);
      chk("full_in_ready", {31'b0, in_ready}, 0);
      chk("stall_instr", out_instr, 32'h00500093);
      chk("stall_addr", out_addr, 32'h0);
      fork
         send(3'd1, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd5, 32'h00500193, 32'h8, 1'b0);
         begin
            repeat (3) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();

      // Illegal format
      send(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0, 32'h0, 32'h0, 1'b1);
      chk("illegal_level", {30'b0, level}, 0);
      @(negedge clk); #1;
      chk("err_one_cycle", {31'b0, err}, 0);

      // ADDI with out-of-range immediate
`ifdef ENC_RANGE_CHECK_EN
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0, 32'h0, 1'b1);
      chk("range_level", {30'b0, level}, 0);
`else
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h80000093, 32'h0C, 1'b0);
`endif
      drain();

      // Address wrap
      load(32'hFFFFFFFC);
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 32'hFFFFFFFC, 1'b0);
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd5, 32'h00500113, 32'h00000000, 1'b0);
      drain();

      // Load wins over a coincident handshake
      out_ready = 1'b0;
      load(32'h40);
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 32'h40, 1'b0);
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd5, 32'h00500113, 32'h200, 1'b0);
      out_ready = 1'b1;
      addr_load = 1'b1;
      addr_val  = 32'h203;
      @(negedge clk);
      addr_load = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("load_prio_addr", out_addr, 32'h200);
      chk("load_prio_level", {30'b0, level}, 1);
      out_ready = 1'b1;
      drain();

      // Asynchronous reset mid-operation
      out_ready = 1'b0;
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 32'h0, 1'b0);
      chk("pre_rst_level", {30'b0, level}, 1);
      #1 rst_n = 1'b0;
      #1;
      q.delete();
      chk("async_rst_valid", {31'b0, out_valid}, 0);
      chk("async_rst_level", {30'b0, level}, 0);
      chk("async_rst_addr", out_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'b0, in_ready}, 1);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
